// File: rtl/pipe_hazard_pkg.sv
// Shared types and constants for the pipeline hazard and forwarding controller.
package pipe_hazard_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    // Widest register address a slot can carry; narrower addresses are zero-extended into it.
    localparam int unsigned SLOT_AW = 8;

    typedef struct packed {
        logic               valid;
        logic [SLOT_AW-1:0] dst;
        logic               reg_write;
        logic               is_load;
    } haz_slot_t;

    // $0 is hard-wired, so a read of it never depends on an in-flight producer.
    function automatic logic src_match(logic use_src, logic [SLOT_AW-1:0] src, haz_slot_t slot);
        return use_src && slot.valid && slot.reg_write && (slot.dst == src) && (src != '0);
    endfunction

endpackage

// File: rtl/pipe_haz_slot.sv
// One tracking slot of the hazard controller: resets to invalid, clear_i inserts an empty slot
// and takes priority over load_i.
module pipe_haz_slot
    import pipe_hazard_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      load_i,
    input  logic      clear_i,
    input  haz_slot_t d_i,
    output haz_slot_t q_o
);

    haz_slot_t slot_d, slot_q;

    always_comb begin
        slot_d = slot_q;
        if (clear_i) begin
            slot_d = '0;
        end else if (load_i) begin
            slot_d = d_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign q_o = slot_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller for a 5-stage pipeline. Define PIPE_FWD_EN to enable EX operand
// forwarding; without it every RAW hazard against EX or MEM stalls and the selects stay 2'b00.
module pipe_hazard_ctrl
    import pipe_hazard_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_use_rs_i,
    input  logic              id_use_rt_i,
    input  logic [REG_AW-1:0] id_dst_i,
    input  logic              id_reg_write_i,
    input  logic              id_is_load_i,
    input  logic              ex_branch_taken_i,
    output logic              pc_we_o,
    output logic              ifid_we_o,
    output logic              ifid_flush_o,
    output logic              idex_bubble_o,
    output logic [1:0]        fwd_a_sel_o,
    output logic [1:0]        fwd_b_sel_o
);

    haz_slot_t          id_slot, ex_slot, mem_slot, wb_slot;
    logic [SLOT_AW-1:0] rs, rt;
    logic               rs_ex, rt_ex, rs_mem, rt_mem;
    logic               stall, flush, bubble, ex_clear;
    logic               unused_wb;

    assign rs = SLOT_AW'(id_rs_i);
    assign rt = SLOT_AW'(id_rt_i);

    assign id_slot = '{valid:     id_valid_i,
                       dst:       SLOT_AW'(id_dst_i),
                       reg_write: id_reg_write_i,
                       is_load:   id_is_load_i};

    assign rs_ex  = src_match(id_use_rs_i, rs, ex_slot);
    assign rt_ex  = src_match(id_use_rt_i, rt, ex_slot);
    assign rs_mem = src_match(id_use_rs_i, rs, mem_slot);
    assign rt_mem = src_match(id_use_rt_i, rt, mem_slot);

    // A taken branch discards the ID instruction, so any stall it would have caused is moot.
    assign flush         = ex_branch_taken_i;
    assign bubble        = flush | stall;
    assign pc_we_o       = flush | ~stall;
    assign ifid_we_o     = flush | ~stall;
    assign ifid_flush_o  = flush;
    assign idex_bubble_o = bubble;
    assign ex_clear      = bubble | ~id_valid_i;

    pipe_haz_slot u_ex_slot (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (1'b1),
        .clear_i (ex_clear),
        .d_i     (id_slot),
        .q_o     (ex_slot)
    );

    pipe_haz_slot u_mem_slot (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (1'b1),
        .clear_i (1'b0),
        .d_i     (ex_slot),
        .q_o     (mem_slot)
    );

    pipe_haz_slot u_wb_slot (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (1'b1),
        .clear_i (1'b0),
        .d_i     (mem_slot),
        .q_o     (wb_slot)
    );

    // WB is tracked for completeness only; the register file is write-before-read.
    assign unused_wb = ^wb_slot;

`ifdef PIPE_FWD_EN
    logic [1:0] fwd_a_d, fwd_a_q, fwd_b_d, fwd_b_q;

    assign stall = ex_slot.is_load & (rs_ex | rt_ex);

    always_comb begin
        fwd_a_d = FWD_REG;
        fwd_b_d = FWD_REG;
        if (!bubble) begin
            if (rs_ex) begin
                fwd_a_d = FWD_MEM;
            end else if (rs_mem) begin
                fwd_a_d = FWD_WB;
            end
            if (rt_ex) begin
                fwd_b_d = FWD_MEM;
            end else if (rt_mem) begin
                fwd_b_d = FWD_WB;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fwd_a_q <= FWD_REG;
            fwd_b_q <= FWD_REG;
        end else begin
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign fwd_a_sel_o = fwd_a_q;
    assign fwd_b_sel_o = fwd_b_q;
`else
    assign stall       = rs_ex | rt_ex | rs_mem | rt_mem;
    assign fwd_a_sel_o = FWD_REG;
    assign fwd_b_sel_o = FWD_REG;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed pipeline scenarios plus random instruction
// streams, checked every cycle against an instruction-level model of the hazard rules.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // Expected stall counts and selects for the directed scenarios in each build.
    localparam int ALU_STALLS = FWD ? 0 : 2;
    localparam int LD_STALLS  = FWD ? 1 : 2;
    localparam int SEL_MEM    = FWD ? 2 : 0;
    localparam int SEL_WB     = FWD ? 1 : 0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_use_rs, id_use_rt, id_reg_write, id_is_load, ex_branch_taken;
    logic [4:0] id_rs, id_rt, id_dst;
    logic       pc_we, ifid_we, ifid_flush, idex_bubble;
    logic [1:0] fwd_a_sel, fwd_b_sel;

    int n_tests = 0;
    int n_fail  = 0;
    bit mdl_stall = 1'b0;

    pipe_hazard_ctrl #(.REG_AW(5)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .id_valid_i        (id_valid),
        .id_rs_i           (id_rs),
        .id_rt_i           (id_rt),
        .id_use_rs_i       (id_use_rs),
        .id_use_rt_i       (id_use_rt),
        .id_dst_i          (id_dst),
        .id_reg_write_i    (id_reg_write),
        .id_is_load_i      (id_is_load),
        .ex_branch_taken_i (ex_branch_taken),
        .pc_we_o           (pc_we),
        .ifid_we_o         (ifid_we),
        .ifid_flush_o      (ifid_flush),
        .idex_bubble_o     (idex_bubble),
        .fwd_a_sel_o       (fwd_a_sel),
        .fwd_b_sel_o       (fwd_b_sel)
    );

    always #5 clk = ~clk;

    // In-flight instruction as seen by the model; chk marks whether its EX selects are defined.
    typedef struct packed {
        logic       v;
        logic [4:0] dst;
        logic       rw;
        logic       ld;
        logic       chk;
        logic [1:0] fa;
        logic [1:0] fb;
    } ent_t;

    localparam ent_t EMPTY = '{v: 1'b0, dst: 5'd0, rw: 1'b0, ld: 1'b0, chk: 1'b1,
                               fa: 2'd0, fb: 2'd0};

    ent_t m_pipe[3];   // index 0 = EX, 1 = MEM, 2 = WB
    ent_t m_next[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit hit(input logic u, input logic [4:0] src, input ent_t e);
        return u && e.v && e.rw && (e.dst == src) && (src != 5'd0);
    endfunction

    // Nearest older producer decides the source: age 0 is the ALU result, age 1 the WB data.
    function automatic logic [1:0] nearest(input logic u, input logic [4:0] src);
        for (int a = 0; a < 2; a++) begin
            if (hit(u, src, m_pipe[a])) return (a == 0) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) m_pipe[i] <= EMPTY;
        end else begin
            for (int i = 0; i < 3; i++) m_pipe[i] <= m_next[i];
        end
    end

    always @(negedge clk) begin : model_cmp
        bit   st;
        bit   bub;
        ent_t e;
        st = 1'b0;
        for (int a = 0; a < 2; a++) begin
            if ((hit(id_use_rs, id_rs, m_pipe[a]) || hit(id_use_rt, id_rt, m_pipe[a])) &&
                (!FWD || (a == 0 && m_pipe[a].ld))) st = 1'b1;
        end
        if (ex_branch_taken) st = 1'b0;
        bub       = ex_branch_taken || st;
        mdl_stall = st;
        check("pc_we", pc_we, !st);
        check("ifid_we", ifid_we, !st);
        check("ifid_flush", ifid_flush, ex_branch_taken);
        check("idex_bubble", idex_bubble, bub);
        if (!rst_n) begin
            check("rst_fwd_a", fwd_a_sel, 0);
            check("rst_fwd_b", fwd_b_sel, 0);
            for (int i = 0; i < 3; i++) m_next[i] = EMPTY;
        end else begin
            if (m_pipe[0].chk) begin
                check("fwd_a_sel", fwd_a_sel, m_pipe[0].fa);
                check("fwd_b_sel", fwd_b_sel, m_pipe[0].fb);
            end
            e     = EMPTY;
            e.v   = id_valid && !bub;
            e.dst = id_dst;
            e.rw  = id_reg_write;
            e.ld  = id_is_load;
            e.chk = bub || id_valid || !FWD;
            if (FWD && !bub) begin
                e.fa = nearest(id_use_rs, id_rs);
                e.fb = nearest(id_use_rt, id_rt);
            end
            m_next[0] = e;
            m_next[1] = m_pipe[0];
            m_next[2] = m_pipe[1];
        end
    end

    task automatic set(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] dst,
                       input logic rw, input logic ld, input logic br);
        id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_dst = dst; id_reg_write = rw; id_is_load = ld; ex_branch_taken = br;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        set(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
    endtask

    // Hold the consumer in ID while stalled, then sample its selects once it sits in EX.
    task automatic consume(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dst,
                           output int nst, output logic [1:0] fa, output logic [1:0] fb);
        set(1, rs, rt, 1, 1, dst, 1, 0, 0);
        nst = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            if (pc_we === 1'b1) break;
            nst++;
            tick();
        end
        tick();
        set(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        fa = fwd_a_sel;
        fb = fwd_b_sel;
    endtask

    task automatic send_rand();
        logic       v, urs, urt, rw, ld, br;
        logic [4:0] rs, rt, dst;
        bit         st;
        v   = ($urandom_range(9) != 0);
        rs  = 5'($urandom_range(3));
        rt  = 5'($urandom_range(3));
        dst = 5'($urandom_range(3));
        urs = 1'($urandom_range(1));
        urt = 1'($urandom_range(1));
        rw  = ($urandom_range(3) != 0);
        ld  = ($urandom_range(2) == 0);
        br  = ($urandom_range(9) == 0);
        set(v, rs, rt, urs, urt, dst, rw, ld, br);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            st = mdl_stall;
            tick();
            if (!st) break;
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        int         nst;
        logic [1:0] fa, fb;
        rst_n = 1'b0;
        set(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // add $3,$1,$2 ; sub $4,$3,$5
        drain();
        set(1, 1, 2, 1, 1, 3, 1, 0, 0); tick();
        consume(3, 5, 4, nst, fa, fb);
        check("alu_raw_stalls", nst, ALU_STALLS);
        check("alu_raw_fwd_a", fa, SEL_MEM);
        check("alu_raw_fwd_b", fb, 0);

        // lw $3,0($1) ; add $4,$2,$3
        drain();
        set(1, 1, 0, 1, 0, 3, 1, 1, 0); tick();
        consume(2, 3, 4, nst, fa, fb);
        check("load_use_stalls", nst, LD_STALLS);
        check("load_use_fwd_a", fa, 0);
        check("load_use_fwd_b", fb, SEL_WB);

        // add $3 ; add $3 ; or $5,$3,$3
        drain();
        set(1, 1, 2, 1, 1, 3, 1, 0, 0); tick();
        set(1, 1, 2, 1, 1, 3, 1, 0, 0); tick();
        consume(3, 3, 5, nst, fa, fb);
        check("youngest_stalls", nst, ALU_STALLS);
        check("youngest_fwd_a", fa, SEL_MEM);
        check("youngest_fwd_b", fb, SEL_MEM);

        // addi $0,$1,4 ; add $2,$0,$0
        drain();
        set(1, 1, 0, 1, 0, 0, 1, 0, 0); tick();
        consume(0, 0, 2, nst, fa, fb);
        check("zero_reg_stalls", nst, 0);
        check("zero_reg_fwd_a", fa, 0);
        check("zero_reg_fwd_b", fb, 0);

        // Taken branch while a load-use hazard sits in ID
        drain();
        set(1, 1, 0, 1, 0, 3, 1, 1, 0); tick();
        set(1, 2, 3, 1, 1, 4, 1, 0, 1);
        @(negedge clk);
        check("br_ifid_flush", ifid_flush, 1);
        check("br_idex_bubble", idex_bubble, 1);
        check("br_pc_we", pc_we, 1);
        check("br_ifid_we", ifid_we, 1);
        tick();
        set(1, 6, 7, 1, 1, 8, 1, 0, 0);
        @(negedge clk);
        check("br_next_pc_we", pc_we, 1);
        check("br_next_bubble", idex_bubble, 0);
        tick();

        // Reset asserted in the middle of a stall
        drain();
        set(1, 1, 0, 1, 0, 3, 1, 1, 0); tick();
        set(1, 2, 3, 1, 1, 4, 1, 0, 0);
        @(negedge clk);
        check("mid_stall_pc_we", pc_we, 0);
        #1 rst_n = 1'b0;
        #1;
        check("in_reset_pc_we", pc_we, 1);
        check("in_reset_bubble", idex_bubble, 0);
        check("in_reset_fwd_a", fwd_a_sel, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_pc_we", pc_we, 1);
        check("post_reset_ifid_we", ifid_we, 1);
        check("post_reset_bubble", idex_bubble, 0);
        tick();

        drain();
        for (int i = 0; i < 1500; i++) send_rand();
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and forwarding controller for the 5-stage pipeline. It tracks the destination registers of the instructions in EX, MEM and WB. It drives the 2-bit selects of the two EX-stage operand forwarding muxes (3-input, 32-bit). It also generates load-use stalls and branch flushes for the IF/ID and ID/EX pipeline registers.

## Interface
- Parameters:
- REG_AW, default 5: register-address width.
- Ports:
- clk, input, 1: pipeline clock.
- rst_n, input, 1: asynchronous, active-low reset.
- id_valid, input, 1: the ID stage holds a real instruction.
- id_rs, input, REG_AW: ID source register A.
- id_rt, input, REG_AW: ID source register B.
- id_use_rs, input, 1: ID reads rs.
- id_use_rt, input, 1: ID reads rt.
- id_dst, input, REG_AW: ID destination register (already muxed rd/rt/31).
- id_reg_write, input, 1: ID writes the register file.
- id_is_load, input, 1: ID is a load.
- ex_branch_taken, input, 1: the branch or jump in EX is taken this cycle.
- pc_we, output, 1: PC write enable (0 = hold).
- ifid_we, output, 1: IF/ID register write enable.
- ifid_flush, output, 1: clear IF/ID to a NOP.
- idex_bubble, output, 1: load a NOP into ID/EX.
- fwd_a_sel, output, 2: EX operand A mux select.
- fwd_b_sel, output, 2: EX operand B mux select.

## Operation
- Forward-select encoding, fixed by the mux structure:
  - 2'b00: register-file value.
  - 2'b10: EX/MEM ALU result.
  - 2'b01: MEM/WB write-back data.
  - 2'b11 is never driven.
- Internal slots EX, MEM and WB each hold {valid, dst, reg_write, is_load}.
- On each clock edge the slots shift ID→EX→MEM→WB.
- The ID→EX entry is invalid when idex_bubble = 1 or id_valid = 0.
- A source "matches" a slot when all of the following hold: use bit = 1, slot valid, slot reg_write = 1, slot dst == source, and source != 0. Register $0 never matches.
- Load-use stall, combinational: the EX slot is a load and matches id_rs or id_rt.
  - Outputs: pc_we = 0, ifid_we = 0, idex_bubble = 1.
  - Lasts exactly 1 cycle per hazard.
- Branch flush: ex_branch_taken = 1 gives ifid_flush = 1 and idex_bubble = 1, with pc_we = 1 and ifid_we = 1.
  - Flush has priority over a load-use stall in the same cycle; the stall is suppressed because the ID instruction is discarded.
- Forward selects are computed in ID and registered on advance.
  - A match against the current EX slot (the next MEM) gives 2'b10.
  - Otherwise, a match against the current MEM slot (the next WB) gives 2'b01.
  - Otherwise the select is 2'b00.
  - The nearest producer wins.
- When idex_bubble = 1, the registered selects are forced to 2'b00.
- The register file is write-before-read, so no WB-to-ID hazard exists.

## Timing
- Reset (asynchronous, rst_n = 0):
  - All slots invalid.
  - fwd_a_sel and fwd_b_sel = 2'b00.
  - Combinational outputs settle to pc_we = 1, ifid_we = 1, ifid_flush = 0, idex_bubble = 0.
- pc_we, ifid_we, ifid_flush and idex_bubble are Mealy outputs, valid in the same cycle as the ID and ex_branch_taken inputs.
- fwd_*_sel are registered and valid throughout the cycle the consumer occupies EX. Latency is 1 clock from ID.
- Load followed immediately by a consumer:
  - 1 stall cycle.
  - The consumer then enters EX with select 2'b01 (load data is in MEM/WB).
- Back-to-back producers to the same register: the younger one wins (2'b10).
- A reset asserted mid-stall aborts the stall. The first cycle after reset has no stall.

## Configuration
- PIPE_FWD_EN defined: forwarding behaves as described above.
- PIPE_FWD_EN undefined:
  - fwd_a_sel and fwd_b_sel are tied to 2'b00.
  - Any match of an ID source against the EX or MEM slot (load or not) stalls, with pc_we = 0, ifid_we = 0 and idex_bubble = 1.
  - This gives up to 2 stall cycles per RAW hazard.
  - Branch flush priority is unchanged.

## Structure
- Package pipe_hazard_pkg holds:
  - localparams FWD_REG = 2'b00, FWD_MEM = 2'b10, FWD_WB = 2'b01;
  - a packed typedef haz_slot_t {valid, dst, reg_write, is_load}.
- One sub-module, pipe_haz_slot: a reset-to-invalid slot register with load and clear controls, instantiated 3 times (EX, MEM, WB).

## Test plan
- `add $3,$1,$2` then `sub $4,$3,$5`: no stall. sub in EX with fwd_a_sel = 2'b10 and fwd_b_sel = 2'b00.
- `lw $3,0($1)` then `add $4,$2,$3`: pc_we = 0, ifid_we = 0 and idex_bubble = 1 for exactly 1 cycle, then add in EX with fwd_b_sel = 2'b01.
- `add $3,..` then `add $3,..` then `or $5,$3,$3`: or in EX with both selects = 2'b10 (youngest producer).
- `addi $0,$1,4` then `add $2,$0,$0`: no stall, selects 2'b00.
- ex_branch_taken = 1 while a load-use hazard is present in ID: ifid_flush = 1, idex_bubble = 1, pc_we = 1, no stall the next cycle.
- PIPE_FWD_EN undefined, `add $3,..` then `sub $4,$3,$5`: 2 stall cycles, then sub in EX with selects 2'b00. Also assert rst_n = 0 mid-stall: all slots clear and pc_we = 1 after release.
